fir_filter_param: RTL and testbench

FIR_FILTER_PARAM -- requirements
Module: fir_filter_param

---
 rtl/fir_filter_param.sv | 158 +++++++++++++++
 tb/tb_fir_filter_param.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_filter_param.sv
// fir_filter_param: sequential FIR filter that uses one shared multiplier.
// Each accepted sample shifts the delay line. The filter then spends TAPS
// cycles on multiply-accumulate, one tap per cycle. The rounded, shifted
// result is held in OUT until the downstream handshake completes.
// Build option: define FIR_FILTER_SAT_EN to saturate the result to DW bits.
// Without it, the result wraps to its low DW bits.
//
// state | meaning
// IDLE  | waiting for a sample (in_ready=1) or a coefficient write
// MAC   | accumulating x[k]*coef[k], one tap per cycle
// OUT   | result valid, holding until out_ready
module fir_filter_param #(
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int TAPS  = 8,
  parameter int SHIFT = 15,
  localparam int AW   = $clog2(TAPS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_data,
  input  logic                 coef_we,
  input  logic [AW-1:0]        coef_addr,
  input  logic signed [CW-1:0] coef_data,
  output logic                 busy
);

  localparam int PW  = DW + CW;
  localparam int ACW = DW + CW + AW;

  localparam logic [ACW:0] RND = {{ACW{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [ACW:0] MAXV = {{(ACW-DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACW:0] MINV = {{(ACW-DW+2){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_OUT
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_en;
  logic signed [DW-1:0]   r_x    [TAPS];
  logic signed [CW-1:0]   r_coef [TAPS];
  logic signed [ACW-1:0]  r_acc;
  logic [AW-1:0]          r_tap;
  logic signed [DW-1:0]   r_out_data;

  logic                   w_accept;
  logic                   w_last;
  logic signed [PW-1:0]   w_prod;
  logic signed [ACW-1:0]  w_prod_ext;
  logic signed [ACW-1:0]  w_sum;
  logic signed [ACW:0]    w_rnd;
  logic signed [ACW:0]    w_shf;
  logic signed [DW-1:0]   w_res;

  // in_ready stays low until the first clock after reset, so r_en gates it.
  assign in_ready  = (r_state == S_IDLE) && r_en;
  assign out_valid = (r_state == S_OUT);
  assign busy      = (r_state != S_IDLE);
  assign out_data  = r_out_data;
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_tap == AW'(TAPS - 1));

  // Shared multiplier. The last tap's product goes straight into the
  // output rounding, so the result is registered on the same edge.
  assign w_prod     = r_x[r_tap] * r_coef[r_tap];
  assign w_prod_ext = ACW'(w_prod);
  assign w_sum      = r_acc + w_prod_ext;
  assign w_rnd      = $signed({w_sum[ACW-1], w_sum}) + $signed(RND);
  assign w_shf      = w_rnd >>> SHIFT;

`ifdef FIR_FILTER_SAT_EN
  // Clamp the shifted result to the signed DW range.
  always_comb begin
    w_res = w_shf[DW-1:0];
    if (w_shf > MAXV)
      w_res = MAXV[DW-1:0];
    else if (w_shf < MINV)
      w_res = MINV[DW-1:0];
  end
`else
  logic w_unused_hi;
  assign w_unused_hi = ^{w_shf[ACW:DW], MAXV, MINV};
  assign w_res       = w_shf[DW-1:0];
`endif

  // State register and the post-reset ready enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_en    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_en    <= 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)  w_state_nxt = S_MAC;
      S_MAC:   if (w_last)    w_state_nxt = S_OUT;
      S_OUT:   if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Delay line: shift in a new sample on each accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < TAPS; k++) r_x[k] <= '0;
    end else if (r_state == S_IDLE && w_accept) begin
      r_x[0] <= in_data;
      for (int k = 1; k < TAPS; k++) r_x[k] <= r_x[k-1];
    end
  end

  // Coefficient bank: writes land only in IDLE when no sample is accepted on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < TAPS; k++) r_coef[k] <= '0;
    end else if (r_state == S_IDLE && coef_we && !w_accept) begin
      r_coef[coef_addr] <= coef_data;
    end
  end

  // Accumulator and tap counter: cleared on accept, stepped in MAC.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc <= '0;
      r_tap <= '0;
    end else if (r_state == S_IDLE && w_accept) begin
      r_acc <= '0;
      r_tap <= '0;
    end else if (r_state == S_MAC && !w_last) begin
      r_acc <= w_sum;
      r_tap <= r_tap + AW'(1);
    end
  end

  // Output register: captured once, on the last MAC cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_out_data <= '0;
    else if (r_state == S_MAC && w_last)
      r_out_data <= w_res;
  end

endmodule

// File: tb/tb_fir_filter_param.sv
// Directed testbench for fir_filter_param with the default parameters (8 taps, Q15).
module tb_fir_filter_param;

  localparam int DW   = 16;
  localparam int CW   = 16;
  localparam int TAPS = 8;
  localparam int AW   = 3;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;
  logic                 coef_we;
  logic [AW-1:0]        coef_addr;
  logic signed [CW-1:0] coef_data;
  logic                 busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  fir_filter_param #(.DW(DW), .CW(CW), .TAPS(TAPS), .SHIFT(15)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset_n = 1'b0; in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic write_coef(input int a, input int d);
    coef_addr = a[AW-1:0];
    coef_data = d[CW-1:0];
    coef_we   = 1'b1;
    @(posedge clk); #1;
    coef_we   = 1'b0;
  endtask

  // Sends one sample and waits for its result, completing the handshake when out_ready=1.
  // lat = edges from the accept edge to the edge that raises out_valid.
  task automatic send_sample(input int d, output int y, output int lat, output int acc_cyc);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    in_data  = d[DW-1:0];
    in_valid = 1'b1;
    @(posedge clk); #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    y = int'(out_data);
    if (out_ready) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || out_data !== '0) begin
      failures++;
      $display("FAIL reset_state in_ready=%b busy=%b out_valid=%b out_data=%0d want 0 0 0 0",
               in_ready, busy, out_valid, out_data);
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #2;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_before_edge got=%b want=0", in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ready_after_edge in_ready=%b busy=%b want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_impulse();
    int y, lat, ac;
    for (int k = 0; k < TAPS; k++) write_coef(k, 1024 * (k + 1));
    for (int j = 0; j < TAPS; j++) begin
      send_sample((j == 0) ? 32767 : 0, y, lat, ac);
      checks++;
      if (y !== 1024 * (j + 1)) begin
        failures++;
        $display("FAIL impulse_out[%0d] got=%0d want=%0d", j, y, 1024 * (j + 1));
      end
      // out_valid is high in cycle TAPS+1, counting the accept cycle as cycle 0.
      checks++;
      if (lat !== TAPS) begin
        failures++;
        $display("FAIL impulse_latency[%0d] got=%0d want=%0d", j, lat + 1, TAPS + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int y1, y2, lat, a1, a2;
    send_sample(0, y1, lat, a1);
    send_sample(0, y2, lat, a2);
    checks++;
    if (a2 - a1 !== TAPS + 2) begin
      failures++;
      $display("FAIL throughput got=%0d want=%0d", a2 - a1, TAPS + 2);
    end
    checks++;
    if (y1 !== 0 || y2 !== 0) begin
      failures++;
      $display("FAIL flush_out got=%0d,%0d want=0,0", y1, y2);
    end
  endtask

  task automatic test_step();
    int y, lat, ac, exp_v;
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, 4096);
    for (int j = 0; j < 10; j++) begin
      send_sample(8000, y, lat, ac);
      exp_v = 1000 * ((j + 1 > TAPS) ? TAPS : j + 1);
      checks++;
      if (y !== exp_v) begin
        failures++;
        $display("FAIL step_out[%0d] got=%0d want=%0d", j, y, exp_v);
      end
    end
  endtask

  task automatic test_rounding();
    int y, lat, ac;
    int xin [4];
    int yex [4];
    xin = '{1, -1, 3, -3};
    yex = '{1, 0, 2, -1};
    do_reset();
    write_coef(0, 16384);
    for (int j = 0; j < 4; j++) begin
      send_sample(xin[j], y, lat, ac);
      checks++;
      if (y !== yex[j]) begin
        failures++;
        $display("FAIL round_out[%0d] x=%0d got=%0d want=%0d", j, xin[j], y, yex[j]);
      end
    end
  endtask

  task automatic test_saturation();
    int y, lat, ac, exp8;
`ifdef FIR_FILTER_SAT_EN
    exp8 = 32767;
`else
    exp8 = -16;
`endif
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, 32767);
    for (int j = 0; j < TAPS; j++) begin
      send_sample(32767, y, lat, ac);
      if (j == 0) begin
        checks++;
        if (y !== 32766) begin
          failures++;
          $display("FAIL sat_first got=%0d want=32766", y);
        end
      end
    end
    checks++;
    if (y !== exp8) begin
      failures++;
      $display("FAIL sat_eighth got=%0d want=%0d", y, exp8);
    end
  endtask

  task automatic test_backpressure();
    int y, lat, ac, n;
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, 1024 * (k + 1));
    out_ready = 1'b0;
    in_data   = 16'sd32767;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'sd1024) begin
      failures++;
      $display("FAIL bp_first_result valid=%b data=%0d want 1 1024", out_valid, out_data);
    end
    in_valid = 1'b1;
    in_data  = 16'sd5000;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'sd1024 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d] valid=%b data=%0d in_ready=%b want 1 1024 0",
                 c, out_valid, out_data, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    send_sample(0, y, lat, ac);
    checks++;
    if (y !== 2048) begin
      failures++;
      $display("FAIL bp_no_consume got=%0d want=2048", y);
    end
  endtask

  task automatic test_mid_op();
    int y, lat, ac, n, seen;
    in_data  = '0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL mac_flags busy=%b in_ready=%b want 1 0", busy, in_ready);
    end
    @(posedge clk); #1;
    write_coef(0, 999);
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (out_data !== 16'sd3072) begin
      failures++;
      $display("FAIL mac_write_result got=%0d want=3072", out_data);
    end
    @(posedge clk); #1;
    for (int j = 0; j < TAPS - 1; j++) send_sample(0, y, lat, ac);
    send_sample(32767, y, lat, ac);
    checks++;
    if (y !== 1024) begin
      failures++;
      $display("FAIL coef_write_ignored got=%0d want=1024", y);
    end
    in_data  = 16'sd100;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset valid=%b data=%0d busy=%b in_ready=%b want 0 0 0 0",
               out_valid, out_data, busy, in_ready);
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL abort_no_result out_valid_cycles=%0d want=0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_back_to_back();
    test_step();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
